id_ex_stage: RTL

- ID/EX pipeline register for the five-stage core. Captures decoded operands and control from ID, and drives the EX-stage ALU inputs (rs1, rs2, imm, ALUCtrl).
- Contains the operand forwarding muxes (EX/MEM, MEM/WB), load-use hazard detection, and stall/flush handling.
- One-cycle register boundary; forwarding and op1 select are combinational on registered state.

---
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control from ID and
// presents forwarded ALU operands to EX, with load-use detection and stall/flush.
module id_ex_stage #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [REG_WIDTH-1:0]     id_pc,
  input  logic [REG_WIDTH-1:0]     id_rs1_data,
  input  logic [REG_WIDTH-1:0]     id_rs2_data,
  input  logic [REG_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_BITS-1:0] id_rs1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rs2_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rd_addr,
  input  logic [ALU_CTRL_BITS-1:0] id_alu_ctrl,
  input  logic                     id_op1_pc,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_BITS-1:0] exmem_rd,
  input  logic [REG_WIDTH-1:0]     exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_BITS-1:0] memwb_rd,
  input  logic [REG_WIDTH-1:0]     memwb_result,
  output logic                     ex_valid,
  output logic [REG_WIDTH-1:0]     ex_pc,
  output logic [REG_WIDTH-1:0]     ex_imm,
  output logic [REG_WIDTH-1:0]     ex_rs1,
  output logic [REG_WIDTH-1:0]     ex_rs2,
  output logic [ALU_CTRL_BITS-1:0] ex_alu_ctrl,
  output logic [REG_ADDR_BITS-1:0] ex_rd_addr,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     load_use_hazard
);

  logic                     valid_q;
  logic [REG_WIDTH-1:0]     pc_q;
  logic [REG_WIDTH-1:0]     imm_q;
  logic [REG_WIDTH-1:0]     rs1_data_q;
  logic [REG_WIDTH-1:0]     rs2_data_q;
  logic [REG_ADDR_BITS-1:0] rs1_addr_q;
  logic [REG_ADDR_BITS-1:0] rs2_addr_q;
  logic [REG_ADDR_BITS-1:0] rd_addr_q;
  logic [ALU_CTRL_BITS-1:0] alu_ctrl_q;
  logic                     op1_pc_q;
  logic                     reg_write_q;
  logic                     mem_read_q;
  logic                     mem_write_q;

  logic [REG_WIDTH-1:0]     fwd_rs1;
  logic [REG_WIDTH-1:0]     fwd_rs2;
  logic                     hazard;

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
  function automatic logic [REG_WIDTH-1:0] forward(
    input logic [REG_ADDR_BITS-1:0] src_addr,
    input logic [REG_WIDTH-1:0]     src_data,
    input logic                     em_we,
    input logic [REG_ADDR_BITS-1:0] em_rd,
    input logic [REG_WIDTH-1:0]     em_res,
    input logic                     mw_we,
    input logic [REG_ADDR_BITS-1:0] mw_rd,
    input logic [REG_WIDTH-1:0]     mw_res
  );
    logic [REG_WIDTH-1:0] value;
    value = src_data;
    if (em_we && em_rd != '0 && em_rd == src_addr)
      value = em_res;
    else if (mw_we && mw_rd != '0 && mw_rd == src_addr)
      value = mw_res;
    return value;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fwd_rs1 = forward(rs1_addr_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
    fwd_rs2 = forward(rs2_addr_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
  end

  // Both sources are compared whatever the format; a spurious stall is harmless.
  assign hazard = id_valid && valid_q && mem_read_q && (rd_addr_q != '0) &&
                  ((id_rs1_addr == rd_addr_q) || (id_rs2_addr == rd_addr_q));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_ctrl_q  <= '0;
      op1_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush || (!stall && hazard)) begin
      // Bubble: only validity and control are cleared, datapath fields hold.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall) begin
      // Refresh operands so a producer that retires during the stall is kept.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      imm_q       <= id_imm;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_addr_q   <= id_rd_addr;
      alu_ctrl_q  <= id_alu_ctrl;
      op1_pc_q    <= id_op1_pc;
      reg_write_q <= id_reg_write & id_valid;
      mem_read_q  <= id_mem_read & id_valid;
      mem_write_q <= id_mem_write & id_valid;
    end
  end

  assign ex_valid        = valid_q;
  assign ex_pc           = pc_q;
  assign ex_imm          = imm_q;
  assign ex_rs1          = op1_pc_q ? pc_q : fwd_rs1;
  assign ex_rs2          = fwd_rs2;
  assign ex_alu_ctrl     = alu_ctrl_q;
  assign ex_rd_addr      = rd_addr_q;
  assign ex_reg_write    = valid_q & reg_write_q;
  assign ex_mem_read     = valid_q & mem_read_q;
  assign ex_mem_write    = valid_q & mem_write_q;
  assign load_use_hazard = hazard;

endmodule
